leaderboard_rank: RTL

- Downstream of the stopwatch core; consumes its 39-bit time word `t` whenever a run is stopped.
- Maintains two sorted top-3 tables:
  - fast board: 3 smallest recorded times.
  - slow board: 3 largest recorded times.
- Drives the rank LEDs, the slow/fast mode LEDs and one-cycle sound triggers for the music block.
- Exports all six entries to the display time MUX.

---
 rtl/leaderboard_rank.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/leaderboard_rank.sv
// leaderboard_rank
//   Keeps two sorted top-3 boards of finished stopwatch runs: the fast board
//   holds the three smallest times, the slow board the three largest. Each
//   accepted record runs IDLE -> CMP -> SHIFT -> ANNOUNCE. Rank, mode and a
//   one-cycle sound pulse are published for the ANNOUNCE cycle.
//
// Ports
//   clock            system clock
//   rst              synchronous active-high reset
//   time_in [TW]     current stopwatch time word
//   record           strobe: capture time_in as a finished run
//   board_sel        0 = fast board, 1 = slow board
//   clear            strobe: empty the selected board (IDLE only, beats record)
//   busy             high while an insertion is in progress
//   fast_1..3 [TW]   fast board entries, 1 = smallest
//   slow_1..3 [TW]   slow board entries, 1 = largest
//   fast_valid[3]    fast board occupied flags, bit0 = entry 1
//   slow_valid[3]    slow board occupied flags, bit0 = entry 1
//   rank [3]         one-hot slot of the last insertion, 000 = not placed
//   lb_mode [2]      01 = last record went to fast board, 10 = slow board
//   signal_sound_1..3  one-cycle pulse on placing 1st / 2nd / 3rd
module leaderboard_rank #(
  parameter int unsigned TW    = 39,
  parameter int unsigned DEPTH = 3
) (
  input  logic          clock,
  input  logic          rst,
  input  logic [TW-1:0] time_in,
  input  logic          record,
  input  logic          board_sel,
  input  logic          clear,
  output logic          busy,
  output logic [TW-1:0] fast_1,
  output logic [TW-1:0] fast_2,
  output logic [TW-1:0] fast_3,
  output logic [TW-1:0] slow_1,
  output logic [TW-1:0] slow_2,
  output logic [TW-1:0] slow_3,
  output logic [2:0]    fast_valid,
  output logic [2:0]    slow_valid,
  output logic [2:0]    rank,
  output logic [1:0]    lb_mode,
  output logic          signal_sound_1,
  output logic          signal_sound_2,
  output logic          signal_sound_3
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_SHIFT,
    S_ANNOUNCE
  } state_t;

  // Slot index meaning "not placed".
  localparam logic [1:0] P_NONE = 2'(DEPTH);

  state_t           r_state;
  logic [TW-1:0]    r_cand;
  logic             r_bsel;
  logic [1:0]       r_pos;
  logic [TW-1:0]    r_fast [DEPTH];
  logic [TW-1:0]    r_slow [DEPTH];
  logic [DEPTH-1:0] r_fast_v;
  logic [DEPTH-1:0] r_slow_v;
  logic [2:0]       r_rank;
  logic [1:0]       r_mode;
  logic             r_busy;
  logic [2:0]       r_snd;

  logic [1:0]       w_pos;
  logic             w_found;

  // First slot that is empty or strictly worse than the candidate; strict
  // compare puts a tie after the existing equal entries.
  always_comb begin
    w_pos   = P_NONE;
    w_found = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!w_found) begin
        if (!r_bsel) begin
          if (!r_fast_v[i] || (r_fast[i] > r_cand)) begin
            w_pos   = 2'(i);
            w_found = 1'b1;
          end
        end else begin
          if (!r_slow_v[i] || (r_slow[i] < r_cand)) begin
            w_pos   = 2'(i);
            w_found = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cand   <= '0;
      r_bsel   <= 1'b0;
      r_pos    <= P_NONE;
      r_fast_v <= '0;
      r_slow_v <= '0;
      r_rank   <= '0;
      r_mode   <= '0;
      r_busy   <= 1'b0;
      r_snd    <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_fast[k] <= '0;
        r_slow[k] <= '0;
      end
    end else begin
      r_snd <= '0;
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            if (!board_sel) begin
              r_fast_v <= '0;
              for (int unsigned k = 0; k < DEPTH; k++) r_fast[k] <= '0;
            end else begin
              r_slow_v <= '0;
              for (int unsigned k = 0; k < DEPTH; k++) r_slow[k] <= '0;
            end
            r_rank <= '0;
          end else if (record) begin
            r_cand  <= time_in;
            r_bsel  <= board_sel;
            r_busy  <= 1'b1;
            r_state <= S_CMP;
          end
        end

        S_CMP: begin
          if (r_cand == '0) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_pos   <= w_pos;
            r_state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          // Entries below the insertion point move down one slot; the last
          // one falls off. With r_pos == P_NONE neither loop fires.
          for (int unsigned k = 1; k < DEPTH; k++) begin
            if (2'(k) > r_pos) begin
              if (!r_bsel) begin
                r_fast[k]   <= r_fast[k-1];
                r_fast_v[k] <= r_fast_v[k-1];
              end else begin
                r_slow[k]   <= r_slow[k-1];
                r_slow_v[k] <= r_slow_v[k-1];
              end
            end
          end
          for (int unsigned k = 0; k < DEPTH; k++) begin
            if (2'(k) == r_pos) begin
              if (!r_bsel) begin
                r_fast[k]   <= r_cand;
                r_fast_v[k] <= 1'b1;
              end else begin
                r_slow[k]   <= r_cand;
                r_slow_v[k] <= 1'b1;
              end
            end
          end
          // Registered here so they are visible during the ANNOUNCE cycle.
          r_rank  <= (r_pos == P_NONE) ? 3'b000 : (3'b001 << r_pos);
          r_snd   <= (r_pos == P_NONE) ? 3'b000 : (3'b001 << r_pos);
          r_mode  <= r_bsel ? 2'b10 : 2'b01;
          r_state <= S_ANNOUNCE;
        end

        S_ANNOUNCE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy           = r_busy;
  assign fast_1         = r_fast[0];
  assign fast_2         = r_fast[1];
  assign fast_3         = r_fast[2];
  assign slow_1         = r_slow[0];
  assign slow_2         = r_slow[1];
  assign slow_3         = r_slow[2];
  assign fast_valid     = r_fast_v;
  assign slow_valid     = r_slow_v;
  assign rank           = r_rank;
  assign lb_mode        = r_mode;
  assign signal_sound_1 = r_snd[0];
  assign signal_sound_2 = r_snd[1];
  assign signal_sound_3 = r_snd[2];

endmodule
